// File: rtl/mem_map_pkg.sv
// Shared address map, widths and FSM encoding for the CPU RAM responder.
package mem_map_pkg;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 62;

    localparam logic [ADDR_W-1:0] LAST_WORD = 6'd61;
    localparam logic [ADDR_W-1:0] CYC_ADDR  = 6'h3E;
    localparam logic [ADDR_W-1:0] LED_ADDR  = 6'h3F;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous multi-bit input word.
module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values: shift the input one stage per clock.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/ram_responder.sv
// CPU data-memory responder: 62-word store, cycle counter and LED register,
// registered read path and a power-up clear sequencer.
module ram_responder
    import mem_map_pkg::*;
(
    input  logic              clk_main,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_to_ram,
    input  logic [DATA_W-1:0] data_to_ram,
    input  logic              write_enable_to_ram,
    input  logic              read_enable_to_ram,
    input  logic              enable_ram_read,
    input  logic [DATA_W-1:0] switches_in,
    output logic [DATA_W-1:0] data_from_ram,
    output logic [DATA_W-1:0] leds_out,
    output logic              init_done
);
    state_e              state_d, state_q;
    logic [ADDR_W-1:0]   clr_cnt_d, clr_cnt_q;
    logic [DATA_W-1:0]   cyc_d, cyc_q;
    logic [DATA_W-1:0]   leds_d, leds_q;
    logic [DATA_W-1:0]   rdata_d, rdata_q;
    logic                init_done_d, init_done_q;
    logic [DATA_W-1:0]   mem_q [MEM_WORDS];
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic [DATA_W-1:0]   sw_sync_s;
    logic [DATA_W-1:0]   src_s;

    sync_2ff #(.WIDTH(DATA_W)) u_sw_sync (
        .clk   (clk_main),
        .rst_n (reset),
        .d     (switches_in),
        .q     (sw_sync_s)
    );

    // Addressed read source, taken from pre-edge state.
    always_comb begin
        src_s = '0;
        if (address_to_ram == CYC_ADDR) begin
            src_s = cyc_q;
        end else if (address_to_ram == LED_ADDR) begin
            src_s = leds_q;
        end else begin
            src_s = mem_q[address_to_ram];
        end
    end

    // Next-state, clear sequencing, write decode and read mux.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        cyc_d       = cyc_q + 16'd1;
        leds_d      = leds_q;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = address_to_ram;
        mem_wdata_s = data_to_ram;
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = '0;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 6'd1;
                end
            end
            READY: begin
                if (write_enable_to_ram) begin
                    if (address_to_ram == LED_ADDR) begin
                        leds_d = data_to_ram;
                    end else if (address_to_ram <= LAST_WORD) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
                // Write-first on a shared address; the counter is not writable.
                if (read_enable_to_ram) begin
                    if (enable_ram_read) begin
                        rdata_d = sw_sync_s;
                    end else if (write_enable_to_ram && (address_to_ram != CYC_ADDR)) begin
                        rdata_d = data_to_ram;
                    end else begin
                        rdata_d = src_s;
                    end
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            cyc_q       <= '0;
            leds_q      <= '0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            cyc_q       <= cyc_d;
            leds_q      <= leds_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage array; zeroed by the clear sequence, not by reset.
    always_ff @(posedge clk_main) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign data_from_ram = rdata_q;
    assign leds_out      = leds_q;
    assign init_done     = init_done_q;
endmodule

// File: tb/tb_ram_responder.sv
// Randomised self-checking bench for ram_responder against a behavioural model.
module tb_ram_responder;
    logic        clk_main = 1'b0;
    logic        reset;
    logic [5:0]  address_to_ram;
    logic [15:0] data_to_ram;
    logic        write_enable_to_ram;
    logic        read_enable_to_ram;
    logic        enable_ram_read;
    logic [15:0] switches_in;
    logic [15:0] data_from_ram;
    logic [15:0] leds_out;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [15:0] m_mem [62];
    logic [15:0] m_leds, m_dfr, m_cyc, m_sw1, m_sw2;
    int          m_edges;

    ram_responder dut (
        .clk_main            (clk_main),
        .reset               (reset),
        .address_to_ram      (address_to_ram),
        .data_to_ram         (data_to_ram),
        .write_enable_to_ram (write_enable_to_ram),
        .read_enable_to_ram  (read_enable_to_ram),
        .enable_ram_read     (enable_ram_read),
        .switches_in         (switches_in),
        .data_from_ram       (data_from_ram),
        .leds_out            (leds_out),
        .init_done           (init_done)
    );

    always #5 clk_main = ~clk_main;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 62; i++) m_mem[i] = 16'h0000;
        m_leds  = 16'h0000;
        m_dfr   = 16'h0000;
        m_cyc   = 16'h0000;
        m_sw1   = 16'h0000;
        m_sw2   = 16'h0000;
        m_edges = 0;
    endtask

    function automatic logic [15:0] model_src(input logic [5:0] a);
        if (a == 6'h3E) return m_cyc;
        if (a == 6'h3F) return m_leds;
        return m_mem[a];
    endfunction

    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            if (m_edges >= 62) begin
                if (read_enable_to_ram) begin
                    if (enable_ram_read) m_dfr = m_sw2;
                    else if (write_enable_to_ram && address_to_ram != 6'h3E) m_dfr = data_to_ram;
                    else m_dfr = model_src(address_to_ram);
                end
                if (write_enable_to_ram) begin
                    if (address_to_ram == 6'h3F) m_leds = data_to_ram;
                    else if (address_to_ram < 6'd62) m_mem[address_to_ram] = data_to_ram;
                end
            end else begin
                m_mem[m_edges] = 16'h0000;
            end
            m_edges++;
            m_cyc = m_cyc + 16'd1;
            m_sw2 = m_sw1;
            m_sw1 = switches_in;
        end
    endtask

    task automatic compare_all();
        check("data_from_ram", data_from_ram, m_dfr);
        check("leds_out", leds_out, m_leds);
        check("init_done", {15'd0, init_done}, {15'd0, (m_edges >= 62)});
    endtask

    task automatic tick(input logic we, input logic re, input logic er,
                        input logic [5:0] a, input logic [15:0] wd);
        write_enable_to_ram = we;
        read_enable_to_ram  = re;
        enable_ram_read     = er;
        address_to_ram      = a;
        data_to_ram         = wd;
        @(posedge clk_main);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] v1, v2;
        logic        rwe, rre, rer;
        logic [5:0]  ra;
        reset = 1'b0;
        switches_in = 16'h0000;
        write_enable_to_ram = 1'b0;
        read_enable_to_ram  = 1'b0;
        enable_ram_read     = 1'b0;
        address_to_ram      = 6'd0;
        data_to_ram         = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk_main);
        #1;
        check("rst_dfr", data_from_ram, 16'h0000);
        check("rst_leds", leds_out, 16'h0000);
        check("rst_init", {15'd0, init_done}, 16'h0000);
        @(negedge clk_main);
        reset = 1'b1;

        // Clear phase with an ignored write to word 2
        for (int i = 1; i <= 61; i++) begin
            if (i == 10) tick(1'b1, 1'b1, 1'b0, 6'h02, 16'hABCD);
            else         tick(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        end
        check("init_low_edge61", {15'd0, init_done}, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check("init_high_edge62", {15'd0, init_done}, 16'h0001);

        tick(1'b0, 1'b1, 1'b0, 6'h10, 16'h0000);
        check("rd_0x10", data_from_ram, 16'h0000);
        tick(1'b0, 1'b1, 1'b0, 6'h02, 16'h0000);
        check("clear_write_ignored", data_from_ram, 16'h0000);

        tick(1'b1, 1'b0, 1'b0, 6'h05, 16'hBEEF);
        tick(1'b0, 1'b1, 1'b0, 6'h05, 16'h0000);
        check("wr_rd_0x05", data_from_ram, 16'hBEEF);

        tick(1'b1, 1'b1, 1'b0, 6'h07, 16'h1234);
        check("write_first", data_from_ram, 16'h1234);

        tick(1'b1, 1'b0, 1'b0, 6'h3F, 16'h00A5);
        check("leds_wr", leds_out, 16'h00A5);
        tick(1'b0, 1'b1, 1'b0, 6'h3F, 16'h0000);
        check("leds_rd", data_from_ram, 16'h00A5);

        switches_in = 16'h5A5A;
        tick(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        tick(1'b0, 1'b1, 1'b1, 6'h05, 16'h0000);
        check("switch_rd", data_from_ram, 16'h5A5A);

        tick(1'b1, 1'b0, 1'b0, 6'h3E, 16'hFFFF);
        tick(1'b0, 1'b1, 1'b0, 6'h3E, 16'h0000);
        v1 = data_from_ram;
        repeat (6) tick(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        tick(1'b0, 1'b1, 1'b0, 6'h3E, 16'h0000);
        v2 = data_from_ram;
        check("cyc_delta", v2 - v1, 16'd7);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) switches_in = 16'($urandom);
            rwe = 1'($urandom);
            rre = 1'($urandom);
            rer = ($urandom_range(0, 3) == 0);
            ra  = ($urandom_range(0, 3) == 0) ? 6'(6'h3C + 6'($urandom_range(0, 3)))
                                              : 6'($urandom_range(0, 15));
            if (rwe && rre && !rer && ra == 6'h3E) rwe = 1'b0;
            tick(rwe, rre, rer, ra, 16'($urandom));
        end

        // Reset mid-operation
        tick(1'b1, 1'b0, 1'b0, 6'h00, 16'h1111);
        tick(1'b1, 1'b0, 1'b0, 6'h3F, 16'h0F0F);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_leds", leds_out, 16'h0000);
        check("midrst_init", {15'd0, init_done}, 16'h0000);
        check("midrst_dfr", data_from_ram, 16'h0000);
        @(negedge clk_main);
        reset = 1'b1;
        repeat (62) tick(1'b0, 1'b1, 1'b0, 6'h00, 16'h0000);
        check("reinit_done", {15'd0, init_done}, 16'h0001);
        tick(1'b0, 1'b1, 1'b0, 6'h00, 16'h0000);
        check("reinit_word0", data_from_ram, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Data-memory responder for the CPU's RAM port: 62 words of 16-bit storage plus two memory-mapped I/O registers, a registered read path, and a power-up clear sequencer. It sits beside the CPU in the top level. It consumes address_to_ram, data_to_ram, write_enable_to_ram, read_enable_to_ram and enable_ram_read, and returns data_from_ram. The top level holds the CPU in reset until init_done is high.

## Interface
- ADDR_W, 6, address width
- DATA_W, 16, data width
- MEM_WORDS, 62, storage words at addresses 0..61
- clk_main  in  1  single system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- address_to_ram  in  ADDR_W  word address from CPU
- data_to_ram  in  DATA_W  write data from CPU
- write_enable_to_ram  in  1  write strobe, sampled on the clock edge
- read_enable_to_ram  in  1  read strobe, sampled on the clock edge
- enable_ram_read  in  1  input-port read select; valid only with read_enable_to_ram
- switches_in  in  DATA_W  asynchronous external input word
- data_from_ram  out  DATA_W  registered read data to CPU
- leds_out  out  DATA_W  LED output register
- init_done  out  1  high once the clear sequence has completed

## Operation
- FSM states:
  - CLEAR: entered on reset. A 6-bit clear counter runs 0..61 and writes 0 to word[counter] once per cycle. After word 61 is written, the FSM moves to READY.
  - READY: terminal state. Exit only by reset.
- In CLEAR, all CPU writes and reads are ignored and data_from_ram holds 0.
- Address map in READY:
  - 0..61: storage.
  - 0x3E (CYC_ADDR): read-only free-running 16-bit cycle counter. It runs from reset release and wraps 0xFFFF→0x0000. Writes to it are ignored.
  - 0x3F (LED_ADDR): leds_out register, read/write.
- Write: in READY with write_enable_to_ram=1, the target selected by address_to_ram loads data_to_ram on the edge.
- Read source, when read_enable_to_ram=1 on an edge in READY:
  - enable_ram_read=0: data_from_ram loads the addressed source (storage, counter or LED register).
  - enable_ram_read=1: data_from_ram loads the synchronized switches_in, regardless of address.
- With read_enable_to_ram=0, data_from_ram holds its value.
- Simultaneous read and write to the same address: write-first. data_from_ram loads data_to_ram.
- enable_ram_read=1 without read_enable_to_ram: no effect.
- switches_in passes through a 2-flop synchronizer before any use.
- Reset mid-CLEAR or mid-READY: all registers return to reset values and the clear restarts from word 0.
- Reset values:
  - data_from_ram = 0, leds_out = 0, init_done = 0
  - cycle counter = 0, clear counter = 0, synchronizer flops = 0
  - FSM = CLEAR
  - Storage is not reset asynchronously; it is zeroed by CLEAR.

## Timing
- Clear sequence: on edge k (k = 1..62) after reset deasserts, word k-1 is cleared. init_done is 1 after edge 62. The first CPU access is honoured on edge 63.
- Read latency: 1 cycle. The value is visible after the edge that sampled read_enable_to_ram.
- Write latency: storage or LED updated at the sampling edge. leds_out changes immediately after that edge. A read of the same word on the next edge returns the new value.
- Counter read: returns the counter value before the sampling edge's increment.
- Switch path: a switches_in change becomes readable after 2 edges, and appears on data_from_ram on the 3rd edge with a read.

## Structure
- Package mem_map_pkg holds:
  - ADDR_W, DATA_W, MEM_WORDS
  - CYC_ADDR = 6'h3E, LED_ADDR = 6'h3F
  - FSM state encoding: CLEAR = 1'b0, READY = 1'b1
- One sub-module: sync_2ff, a parameterised-width two-flop synchronizer with async active-low reset, used for switches_in.
- Storage array, FSM, counters and read mux live in ram_responder.

## Test plan
- Reset release, idle: init_done low through edge 61 and high after edge 62. A read of word 0x10 then returns 0x0000.
- Write then read: after init, write 0xBEEF to 0x05, then read 0x05 on the next cycle. data_from_ram = 0xBEEF one cycle after the read edge.
- Write-first: write and read 0x1234 to 0x07 on the same edge. data_from_ram = 0x1234 after that edge.
- I/O:
  - Write 0x00A5 to 0x3F: leds_out = 0x00A5 and a read of 0x3F returns 0x00A5.
  - Set switches_in = 0x5A5A, then read with enable_ram_read=1 at address 0x05 three edges later: returns 0x5A5A, not 0xBEEF.
- Ignored accesses:
  - Write 0xFFFF to 0x3E: the counter is unaffected, so two reads N cycles apart differ by N.
  - A write during CLEAR to 0x02: word 0x02 reads 0x0000 after init.
- Reset mid-operation: assert reset after writing 0x1111 to 0x00 and release it. leds_out = 0 and init_done = 0 at once. After 62 edges, word 0x00 reads 0x0000.
